// File: rtl/dtt_crossbar_egress_queue.sv
// Per-port egress FIFOs behind the crossbar: one show-ahead queue per output,
// drops (and counts) words that arrive while the queue is full.
module dtt_crossbar_egress_queue #(
    parameter int N_OUT      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int LW         = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_OUT*DATA_WIDTH-1:0] in_data,
    input  logic [N_OUT-1:0]            in_valid,
    output logic [N_OUT*DATA_WIDTH-1:0] eg_data,
    output logic [N_OUT-1:0]            eg_valid,
    input  logic [N_OUT-1:0]            eg_ready,
    output logic [N_OUT*LW-1:0]         eg_level,
    output logic [N_OUT*CNT_WIDTH-1:0]  drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0]        LEVEL_FULL = LW'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_port
            logic [DATA_WIDTH-1:0] mem [DEPTH];
            logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
            logic [LW-1:0]         level_reg, level_next;
            logic [CNT_WIDTH-1:0]  drop_reg, drop_next;
            logic                  full, empty, push, pop;

            assign full  = (level_reg == LEVEL_FULL);
            assign empty = (level_reg == '0);
            // A pop in the same cycle frees the slot, so a full queue still accepts.
            assign pop   = !empty && eg_ready[gi];
            assign push  = in_valid[gi] && (!full || pop);

            always_comb begin
                level_next = level_reg;
                drop_next  = drop_reg;
                case ({push, pop})
                    2'b10:   level_next = level_reg + LW'(1);
                    2'b01:   level_next = level_reg - LW'(1);
                    default: level_next = level_reg;
                endcase
                if (in_valid[gi] && !push && drop_reg != CNT_MAX)
                    drop_next = drop_reg + CNT_WIDTH'(1);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    level_reg  <= '0;
                    drop_reg   <= '0;
                end else begin
                    if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
                    level_reg <= level_next;
                    drop_reg  <= drop_next;
                end
            end

            // Storage carries no reset so it maps onto plain RAM.
            always_ff @(posedge clk) begin
                if (push) mem[wr_ptr_reg] <= in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            end

            assign eg_valid[gi]                          = !empty;
            assign eg_data[gi*DATA_WIDTH +: DATA_WIDTH]  = empty ? '0 : mem[rd_ptr_reg];
            assign eg_level[gi*LW +: LW]                 = level_reg;
            assign drop_cnt[gi*CNT_WIDTH +: CNT_WIDTH]   = drop_reg;
        end
    endgenerate
endmodule

// File: tb/tb_dtt_crossbar_egress_queue.sv
// Directed + random bench for the egress queues, checked against a queue model.
module tb_dtt_crossbar_egress_queue;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int D  = 4;
    localparam int CW = 2;
    localparam int LW = $clog2(D + 1);
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 0;
    logic              rst_n = 0;
    logic [N*DW-1:0]   in_data = '0;
    logic [N-1:0]      in_valid = '0;
    logic [N*DW-1:0]   eg_data;
    logic [N-1:0]      eg_valid;
    logic [N-1:0]      eg_ready = '0;
    logic [N*LW-1:0]   eg_level;
    logic [N*CW-1:0]   drop_cnt;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] q [N][$];
    int            dm [N];

    dtt_crossbar_egress_queue #(.N_OUT(N), .DATA_WIDTH(DW), .DEPTH(D), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .eg_data(eg_data), .eg_valid(eg_valid), .eg_ready(eg_ready),
        .eg_level(eg_level), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int j = 0; j < N; j++) begin
            logic [DW-1:0] head;
            head = (q[j].size() != 0) ? q[j][0] : '0;
            chk($sformatf("valid[%0d]", j), 64'(eg_valid[j]), 64'(q[j].size() != 0));
            chk($sformatf("data[%0d]", j), 64'(eg_data[j*DW +: DW]), 64'(head));
            chk($sformatf("level[%0d]", j), 64'(eg_level[j*LW +: LW]), 64'(q[j].size()));
            chk($sformatf("drop[%0d]", j), 64'(drop_cnt[j*CW +: CW]), 64'(dm[j]));
        end
    endtask

    // One clock: model applies the queue rules to inputs seen at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        for (int j = 0; j < N; j++) begin
            bit pop_m, acc;
            pop_m = (q[j].size() != 0) && eg_ready[j];
            acc   = in_valid[j] && ((q[j].size() < D) || pop_m);
            if (pop_m) void'(q[j].pop_front());
            if (acc) q[j].push_back(in_data[j*DW +: DW]);
            else if (in_valid[j] && dm[j] < CMAX) dm[j]++;
        end
        #1;
        check_all();
    endtask

    task automatic push1(input int p, input logic [DW-1:0] v, input bit rdy);
        in_data[p*DW +: DW] = v;
        in_valid[p] = 1'b1;
        eg_ready[p] = rdy;
        tick();
        in_valid[p] = 1'b0;
        eg_ready[p] = 1'b0;
    endtask

    task automatic drain_port(input int p);
        eg_ready[p] = 1'b1;
        for (int k = 0; k < D + 1; k++) tick();
        eg_ready[p] = 1'b0;
    endtask

    task automatic model_clear();
        for (int j = 0; j < N; j++) begin
            q[j].delete();
            dm[j] = 0;
        end
    endtask

    initial begin
        model_clear();
        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        check_all();
        $display("reset: total=%0d bad=%0d", total, bad);
        rst_n = 1;

        // Single word on port 2
        push1(2, 32'hAAAA_BBBB, 0);
        chk("single_data", 64'(eg_data[2*DW +: DW]), 64'hAAAA_BBBB);
        chk("single_level", 64'(eg_level[2*LW +: LW]), 64'd1);
        eg_ready[2] = 1; tick(); eg_ready[2] = 0;
        chk("single_pop_valid", 64'(eg_valid[2]), 64'd0);
        $display("single word: total=%0d bad=%0d", total, bad);

        // Parallel ports 1 and 3
        in_data[1*DW +: DW] = 32'hEEEE_FFFF;
        in_data[3*DW +: DW] = 32'h1111_2222;
        in_valid = 4'b1010;
        tick();
        in_valid = '0;
        chk("par_p1", 64'(eg_data[1*DW +: DW]), 64'hEEEE_FFFF);
        chk("par_p3", 64'(eg_data[3*DW +: DW]), 64'h1111_2222);
        chk("par_empty", 64'({eg_valid[2], eg_valid[0]}), 64'd0);
        eg_ready = '1; tick(); eg_ready = '0;
        $display("parallel: total=%0d bad=%0d", total, bad);

        // Overflow on port 0
        for (int k = 0; k < 6; k++) push1(0, DW'(k), 0);
        chk("ovf_level", 64'(eg_level[0 +: LW]), 64'd4);
        chk("ovf_drop", 64'(drop_cnt[0 +: CW]), 64'd2);
        for (int k = 0; k < 4; k++) begin
            chk("ovf_order", 64'(eg_data[0 +: DW]), 64'(k));
            eg_ready[0] = 1; tick(); eg_ready[0] = 0;
        end
        $display("overflow: total=%0d bad=%0d", total, bad);

        // Full with simultaneous push and pop
        for (int k = 10; k < 14; k++) push1(0, DW'(k), 0);
        push1(0, 32'd14, 1);
        chk("fullpp_drop", 64'(drop_cnt[0 +: CW]), 64'd2);
        chk("fullpp_level", 64'(eg_level[0 +: LW]), 64'd4);
        for (int k = 11; k < 15; k++) begin
            chk("fullpp_order", 64'(eg_data[0 +: DW]), 64'(k));
            eg_ready[0] = 1; tick(); eg_ready[0] = 0;
        end
        $display("full push+pop: total=%0d bad=%0d", total, bad);

        // Streaming through the pointer wrap
        eg_ready[3] = 1;
        for (int k = 0; k < 20; k++) begin
            in_data[3*DW +: DW] = DW'(32'h100 + k);
            in_valid[3] = 1;
            tick();
            chk("stream_level", 64'(eg_level[3*LW +: LW]), 64'd1);
            chk("stream_data", 64'(eg_data[3*DW +: DW]), 64'(32'h100 + k));
        end
        in_valid[3] = 0;
        tick();
        eg_ready[3] = 0;
        $display("stream: total=%0d bad=%0d", total, bad);

        // Drop counter saturation (2-bit counter)
        for (int k = 0; k < 9; k++) push1(0, DW'(32'h200 + k), 0);
        chk("sat_drop", 64'(drop_cnt[0 +: CW]), 64'd3);
        drain_port(0);
        $display("saturation: total=%0d bad=%0d", total, bad);

        // Asynchronous reset mid-stream
        for (int k = 0; k < 3; k++) push1(1, DW'(32'h300 + k), 0);
        rst_n = 0;
        #1;
        model_clear();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1;
        check_all();
        $display("async reset: total=%0d bad=%0d", total, bad);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            for (int j = 0; j < N; j++) in_data[j*DW +: DW] = $urandom;
            in_valid = 4'($urandom);
            eg_ready = 4'($urandom) & 4'($urandom);
            tick();
        end
        in_valid = '0;
        eg_ready = '1;
        repeat (D + 1) tick();
        $display("random: total=%0d bad=%0d", total, bad);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dtt_crossbar_egress_queue.md
Name: dtt_crossbar_egress_queue

Overview:
Per-output-port egress buffering stage directly downstream of dtt_crossbar_switch. Each crossbar output (out_data/out_valid, no backpressure) feeds one independent FIFO. Each FIFO drains to its consumer over a valid/ready handshake. Words arriving at a full queue are dropped and counted, since the crossbar cannot be stalled.

Parameters:
N_OUT, 4, number of crossbar output ports / independent queues
DATA_WIDTH, 32, payload width
DEPTH, 4, entries per queue; power of two, >= 2
CNT_WIDTH, 8, width of per-port drop counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  [DATA_WIDTH-1:0] x N_OUT  crossbar out_data per port
in_valid  input  1 x N_OUT  crossbar out_valid per port
eg_data  output  [DATA_WIDTH-1:0] x N_OUT  head-of-queue data per port
eg_valid  output  1 x N_OUT  queue non-empty
eg_ready  input  1 x N_OUT  consumer accepts head this cycle
eg_level  output  [$clog2(DEPTH+1)-1:0] x N_OUT  current occupancy, 0..DEPTH
drop_cnt  output  [CNT_WIDTH-1:0] x N_OUT  saturating count of dropped words

Behaviour:
- Reset (rst_n low, asynchronous, any cycle, including mid-traffic):
  - Read/write pointers and levels go to 0.
  - eg_valid = 0, eg_data = 0, eg_level = 0, drop_cnt = 0.
  - Queue contents are discarded.
- Ports are fully independent; there is no cross-port interaction.
- Push: in_valid[j] sampled at a rising edge writes in_data[j] at the tail when the queue is not full.
- Pop: occurs at a rising edge when eg_valid[j] && eg_ready[j]; the head advances.
- Show-ahead output:
  - eg_valid[j] = (level != 0).
  - eg_data[j] = current head entry while non-empty, 0 while empty.
  - All outputs are registered or derived purely from state; no combinational path from in_* or eg_ready to any output.
- Latency: a word pushed at edge k is visible on eg_data/eg_valid after edge k (one cycle). There is no empty-queue bypass.
- Simultaneous push and pop:
  - Not full, non-empty: both occur, level unchanged.
  - Full: the pop frees a slot and the push is accepted, level stays DEPTH, no drop.
  - Empty: only the push occurs (eg_valid was 0).
- Full with in_valid and no pop: the word is dropped, contents are unchanged, and drop_cnt[j] increments.
- drop_cnt saturates at 2^CNT_WIDTH-1 and never wraps.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are decided by the level counter, never by pointer equality alone.
- eg_ready while empty has no effect.
- Ordering: FIFO order per port is strictly preserved.

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles -> all eg_valid=0, eg_data=0, eg_level=0, drop_cnt=0. Assert rst_n low mid-stream with 3 words queued -> outputs return to 0 immediately (before the next edge).
- Single word: in_data[2]=32'hAAAA_BBBB with in_valid[2]=1 for one cycle, eg_ready=0 -> next cycle eg_valid[2]=1, eg_data[2]=AAAA_BBBB, eg_level[2]=1. Raise eg_ready[2] for one cycle -> eg_valid[2]=0, eg_level[2]=0.
- Parallel ports: push 32'hEEEE_FFFF to port 1 and 32'h1111_2222 to port 3 on the same edge -> both visible next cycle, ports 0 and 2 stay empty.
- Overflow: with eg_ready[0]=0, push 6 words 0..5 to port 0 (DEPTH=4) -> eg_level[0]=4, drop_cnt[0]=2. Draining yields 0,1,2,3 in order.
- Full with simultaneous push and pop: fill port 0 with 10,11,12,13, then push 14 with eg_ready[0]=1 -> drop_cnt unchanged, level stays 4, drain order is 11,12,13,14.
- Wrap and saturation:
  - Stream 20 words with eg_ready held at 1 -> all received in order, level never exceeds 1.
  - With CNT_WIDTH=2, drop 5 words -> drop_cnt=3.
